// File: rtl/module_pipe_flopr.sv
// -----------------------------------------------------------------------------
// module_pipe_flopr
//
// Elastic register pipeline of DEPTH stages with valid/ready handshaking on
// both sides. Each stage holds a valid bit and a WIDTH-bit data register.
// A stage accepts new contents whenever it is empty or the stage after it is
// moving, so bubbles travel down the pipe while data flows and are squeezed
// out while the output is stalled. A synchronous flush drops every stored
// item without touching the data registers.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_i        asynchronous reset, active low; clears valid and data
//   flush_i      synchronous flush of all stored items
//   in_valid_i   upstream item present on in_data_i
//   in_data_i    upstream data, WIDTH bits
//   in_ready_o   pipeline accepts the upstream item this cycle
//   out_valid_o  item present on out_data_o (flop output)
//   out_data_o   data of the last stage (flop output)
//   out_ready_i  downstream accepts the item this cycle
//   count_o      number of occupied stages, 0..DEPTH (flop output)
//
// The only combinational input-to-output path is out_ready_i/flush_i to
// in_ready_o through the stage ready chain.
// -----------------------------------------------------------------------------
module module_pipe_flopr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  // Stage state: index 0 is the input stage, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Occupancy is kept in its own register so count_o is a pure flop output.
  logic [CW-1:0] count_q, count_d;

  // Per-stage ready, and what each stage would load from its upstream side.
  logic [DEPTH-1:0] stage_ready;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];

  // ---------------------------------------------------------------------------
  // Ready chain, walked from the output end back to the input stage. A running
  // local carries ready[k+1] so the vector never reads its own bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition;
    // a path that leaves a signal unassigned would infer a latch.
    logic r;
    stage_ready = '0;
    r           = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r              = !valid_q[k] || r;
      stage_ready[k] = r;
    end
  end

  // Flush blocks the input transfer but leaves the output transfer alone.
  assign in_ready_o = stage_ready[0] && !flush_i;

  // ---------------------------------------------------------------------------
  // Upstream view of each stage: stage 0 sees the input port, stage k sees
  // stage k-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    up_valid[0] = in_valid_i;
    up_data[0]  = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: ready stages shift, non-ready stages hold. Data only follows a
  // valid item, so a bubble leaves the previous data in place. Flush clears
  // every valid bit and freezes the data registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (stage_ready[k]) begin
        valid_d[k] = up_valid[k];
        if (up_valid[k] && !flush_i) begin
          data_d[k] = up_data[k];
        end
      end
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Population count of the next valid vector, registered alongside it.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(valid_d[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      count_q <= '0;
      // NOTE: the data registers are reset as well because out_data_o must
      // read 0 straight out of reset; storage that nobody observes before it
      // is written would normally be left unreset.
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign count_o     = count_q;

endmodule

// File: tb/tb_module_pipe_flopr.sv
// -----------------------------------------------------------------------------
// tb_module_pipe_flopr
//
// Bench for module_pipe_flopr with WIDTH=8, DEPTH=3: a vector table for the
// basic stream, hand-written sequences for backpressure, full push/pop,
// flush, asynchronous reset and bubble compression, then a randomized run
// against a slot/queue reference model.
// -----------------------------------------------------------------------------
module tb_module_pipe_flopr;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i;
  logic [1:0]       count_o;

  int n_checks = 0;
  int n_fail   = 0;

  module_pipe_flopr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs shortly after the falling edge and let them settle.
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Push items with the output stalled.
  task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(1'b1, a, 1'b0, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0); tick();
    drive(1'b1, c, 1'b0, 1'b0); tick();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs for one cycle and the outputs expected before the
  // rising edge of that cycle. Data is compared only when valid is expected.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_data;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl[8];

  // ---------------------------------------------------------------------------
  // Reference model for the random run. Slots hold occupancy only; the queue
  // holds accepted, undelivered items in order, so its front is always the
  // item expected at the output.
  // ---------------------------------------------------------------------------
  bit         mv[3];
  logic [7:0] sb[$];

  task automatic rand_cycle();
    bit         iv, ordy, fl, pop, acc, exp_ir;
    bit         t[3];
    logic [7:0] d;
    int         cnt;
    iv   = ($urandom_range(0, 99) < 70);
    ordy = ($urandom_range(0, 99) < 60);
    fl   = ($urandom_range(0, 99) < 4);
    d    = 8'($urandom);
    drive(iv, d, ordy, fl);

    // Item at the last slot leaves if taken; every item then advances into
    // an empty slot ahead of it. The input slot is free only if it empties.
    pop = mv[2] && ordy;
    t   = mv;
    if (pop) t[2] = 1'b0;
    for (int k = 2; k > 0; k--) begin
      if (!t[k]) begin
        t[k]   = t[k-1];
        t[k-1] = 1'b0;
      end
    end
    exp_ir = !t[0] && !fl;
    cnt    = int'(mv[0]) + int'(mv[1]) + int'(mv[2]);

    check("rand in_ready", 32'(in_ready_o), 32'(exp_ir));
    check("rand out_valid", 32'(out_valid_o), 32'(mv[2]));
    check("rand count", 32'(count_o), 32'(cnt));
    if (mv[2] && sb.size() > 0) check("rand out_data", 32'(out_data_o), 32'(sb[0]));

    acc = iv && exp_ir;
    @(posedge clk_i);
    if (pop && sb.size() > 0) void'(sb.pop_front());
    if (acc) begin
      t[0] = 1'b1;
      sb.push_back(d);
    end
    if (fl) begin
      t = '{default: 1'b0};
      sb.delete();
    end
    mv = t;
    @(negedge clk_i);
  endtask

  initial begin
    // Reset state, checked while reset is held.
    rst_i = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("reset out_valid", 32'(out_valid_o), 32'h0);
    check("reset out_data", 32'(out_data_o), 32'h0);
    check("reset count", 32'(count_o), 32'h0);
    check("reset in_ready", 32'(in_ready_o), 32'h1);
    flush_i = 1'b1; #1;
    check("reset in_ready flush", 32'(in_ready_o), 32'h0);
    flush_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Stream with out_ready held: 0x11 appears after the third edge.
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
    tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd3};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd2};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      check($sformatf("stream[%0d] in_ready", i), 32'(in_ready_o), 32'(tbl[i].e_ir));
      check($sformatf("stream[%0d] out_valid", i), 32'(out_valid_o), 32'(tbl[i].e_ov));
      check($sformatf("stream[%0d] count", i), 32'(count_o), 32'(tbl[i].e_cnt));
      if (tbl[i].e_ov) check($sformatf("stream[%0d] out_data", i), 32'(out_data_o), 32'(tbl[i].e_data));
      tick();
    end

    // Backpressure: three accepts then stall, no stage moves while full.
    do_reset();
    fill(8'h01, 8'h02, 8'h03);
    drive(1'b1, 8'h04, 1'b0, 1'b0);
    check("bp full in_ready", 32'(in_ready_o), 32'h0);
    check("bp full count", 32'(count_o), 32'd3);
    tick();
    check("bp hold count", 32'(count_o), 32'd3);
    check("bp hold head", 32'(out_data_o), 32'h01);
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    check("bp release in_ready", 32'(in_ready_o), 32'h1);
    check("bp out 01", 32'(out_data_o), 32'h01);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp out 02", 32'(out_data_o), 32'h02);
    tick();
    check("bp out 03", 32'(out_data_o), 32'h03);
    tick();
    check("bp out 04 valid", 32'(out_valid_o), 32'h1);
    check("bp out 04", 32'(out_data_o), 32'h04);
    tick();
    check("bp drained", 32'(out_valid_o), 32'h0);

    // Full with simultaneous push and pop.
    do_reset();
    fill(8'hA1, 8'hA2, 8'hA3);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    check("pp in_ready", 32'(in_ready_o), 32'h1);
    check("pp head", 32'(out_data_o), 32'hA1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pp count", 32'(count_o), 32'd3);
    check("pp next head", 32'(out_data_o), 32'hA2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    check("pp AA out", 32'(out_data_o), 32'hAA);
    check("pp AA valid", 32'(out_valid_o), 32'h1);

    // Flush while full: head delivered, input refused, data registers kept.
    do_reset();
    fill(8'hB1, 8'hB2, 8'hB3);
    drive(1'b1, 8'hCC, 1'b1, 1'b1);
    check("flush in_ready", 32'(in_ready_o), 32'h0);
    check("flush head valid", 32'(out_valid_o), 32'h1);
    check("flush head", 32'(out_data_o), 32'hB1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush out_valid", 32'(out_valid_o), 32'h0);
    check("flush count", 32'(count_o), 32'd0);
    check("flush data kept", 32'(out_data_o), 32'hB1);

    // Asynchronous reset between edges with two items in flight.
    do_reset();
    drive(1'b1, 8'h61, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h62, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("ar pre count", 32'(count_o), 32'd2);
    #1 rst_i = 1'b0;
    #1;
    check("ar out_valid", 32'(out_valid_o), 32'h0);
    check("ar out_data", 32'(out_data_o), 32'h0);
    check("ar count", 32'(count_o), 32'd0);
    check("ar in_ready", 32'(in_ready_o), 32'h1);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    check("ar accept", 32'(in_ready_o), 32'h1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("ar lat1", 32'(out_valid_o), 32'h0);
    tick();
    check("ar lat2", 32'(out_valid_o), 32'h0);
    tick();
    check("ar lat3 valid", 32'(out_valid_o), 32'h1);
    check("ar lat3 data", 32'(out_data_o), 32'h5A);

    // Bubble compression under stall.
    do_reset();
    drive(1'b1, 8'h10, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h20, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("bub count", 32'(count_o), 32'd2);
    check("bub head", 32'(out_data_o), 32'h10);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("bub out 10", 32'(out_data_o), 32'h10);
    tick();
    check("bub out 20 valid", 32'(out_valid_o), 32'h1);
    check("bub out 20", 32'(out_data_o), 32'h20);

    // Randomized run against the reference model.
    do_reset();
    mv = '{default: 1'b0};
    sb.delete();
    for (int i = 0; i < 3000; i++) begin
      rand_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
